// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, the NOP
// bubble word, the sequential PC step and the queue entry layout.
package if_pkg;
  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched {instr, pc} words for decode.
// Flush dominates push/pop; the head word is read straight from storage.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage carries no reset; validity is tracked purely by r_count.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push && !i_pop && !i_flush)
      assert (r_count != CW'(DEPTH)) else $error("fetch_fifo overflow");
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: credit-limited in-order requests to imem,
// a DEPTH-entry queue toward decode, and redirect with stale-response drop.
module if_fetch_queue #(
  parameter int              XLEN      = if_pkg::XLEN,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  import if_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_credits_used;
  logic              w_accept;
  logic              w_rsp_drop;
  logic              w_rsp_take;
  logic              w_pop;
  logic [XLEN-1:0]   w_rsp_pc;
  logic [2*XLEN-1:0] w_head;

  // Queued plus in-flight words never exceed DEPTH, so a kept response always fits.
  assign w_credits_used = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !redirect_valid && (w_credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_take = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop      = id_valid && id_ready && !redirect_valid;

  // Non-stale in-flight requests are contiguous and end just below fetch_pc,
  // so the oldest one's PC is recovered without a separate PC FIFO.
  assign w_rsp_pc = r_fetch_pc - XLEN'(r_outstanding) * XLEN'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= redirect_pc;
      r_outstanding <= '0;
      r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(imem_rsp_valid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_take);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_rsp_take),
    .i_data  ({imem_rsp_data, w_rsp_pc}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign id_valid = (w_count != '0);
  assign id_instr = id_valid ? w_head[2*XLEN-1:XLEN] : NOP_INSTR;
  assign id_pc    = id_valid ? w_head[XLEN-1:0] : '0;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: latency-configurable in-order memory model and a
// scoreboard of expected {instr, pc} pairs filled on request acceptance.
module tb_if_fetch_queue;
  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  if_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        memq[$];
  fetch_entry_t sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           lat = 1;
  int           n_accept = 0;
  logic         rdy_rand = 1'b0;
  logic [31:0]  exp_addr = 32'h0;
  logic         prev_stall = 1'b0;
  logic [31:0]  prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: in-order responses, each no earlier than lat cycles after acceptance.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rst && memq.size() != 0 && memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: evaluates the handshakes that complete at the coming rising edge.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst) begin
      sb.delete();
      memq.delete();
      exp_addr   = 32'h0;
      n_accept   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("addr_hold", imem_req_addr, prev_addr);
      if (redirect_valid) begin
        check("req_in_redirect", 32'(imem_req_valid), 32'd0);
        sb.delete();
        exp_addr = redirect_pc;
      end else begin
        if (id_valid && id_ready) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("id_pc", id_pc, e.pc);
            check("id_instr", id_instr, e.instr);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_addr);
          e.pc    = exp_addr;
          e.instr = mem_word(exp_addr);
          sb.push_back(e);
          exp_addr = exp_addr + 32'd4;
          n_accept++;
        end
      end
      if (imem_rsp_valid && memq.size() != 0) memq.delete(0);
      if (imem_req_valid && imem_req_ready)
        memq.push_back('{addr: imem_req_addr, due: cyc + lat});
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l, input logic rr);
    @(posedge clk);
    #2;
    rst = 1'b1;
    lat = l;
    rdy_rand = rr;
    redirect_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input string tag);
    int exp_drop;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check({tag, "_req_off"}, 32'(imem_req_valid), 32'd0);
    exp_drop = memq.size() - int'(imem_rsp_valid);
    step();
    redirect_valid = 1'b0;
    #1;
    check({tag, "_empty"}, 32'(id_valid), 32'd0);
    check({tag, "_drop"}, 32'(dut.r_drop_cnt), 32'(exp_drop));
    check({tag, "_addr"}, imem_req_addr, pc);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (3) step();
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);

    // Streaming with 1-cycle memory.
    rst = 1'b0;
    #1;
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    step();
    check("c1_id_valid", 32'(id_valid), 32'd0);
    step();
    check("c2_id_valid", 32'(id_valid), 32'd1);
    check("c2_id_pc", id_pc, 32'h0);
    step();
    check("c3_id_pc", id_pc, 32'h4);
    step();
    check("c4_id_pc", id_pc, 32'h8);
    repeat (6) step();

    // Decode back-pressure: credits cap acceptance at DEPTH.
    id_ready = 1'b0;
    do_reset(1, 1'b0);
    repeat (12) step();
    check("bp_accepts", 32'(n_accept), 32'd4);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_head_pc", id_pc, 32'h0);
    step();
    check("bp_hold_pc", id_pc, 32'h0);
    check("bp_hold_instr", id_instr, mem_word(32'h0));
    id_ready = 1'b1;
    repeat (15) step();
    check("bp_resume", 32'(n_accept > 8), 32'd1);

    // Redirect with two 3-cycle requests in flight.
    do_reset(3, 1'b0);
    step();
    step();
    do_redirect(32'h0000_0100, "t3");
    k = 0;
    while (!id_valid && k < 20) begin
      step();
      k++;
    end
    check("t3_latency", 32'(k), 32'd4);
    check("t3_first_pc", id_pc, 32'h0000_0100);
    repeat (6) step();

    // Redirect coinciding with a response and a pop.
    do_reset(1, 1'b0);
    repeat (5) step();
    check("t4_rsp_pre", 32'(imem_rsp_valid), 32'd1);
    check("t4_pop_pre", 32'(id_valid && id_ready), 32'd1);
    do_redirect(32'h0000_0200, "t4");
    repeat (6) step();

    // Random memory and decode stalls with occasional redirects.
    do_reset(2, 1'b1);
    for (int i = 0; i < 300; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;

    // Address wrap, then asynchronous reset mid-burst.
    do_reset(1, 1'b0);
    repeat (3) step();
    do_redirect(32'hFFFF_FFFC, "wrap");
    step();
    check("wrap_next_addr", imem_req_addr, 32'h0);
    step();
    check("wrap_pc_hi", id_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc_lo", id_pc, 32'h0);
    repeat (3) step();
    check("pre_rst_valid", 32'(id_valid), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_id_valid", 32'(id_valid), 32'd0);
    check("arst_id_instr", id_instr, 32'h0000_0013);
    check("arst_id_pc", id_pc, 32'h0);
    check("arst_req_addr", imem_req_addr, 32'h0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
